sum_serie_ctrl: RTL and testbench



---
 rtl/sum_serie_pkg.sv | 25 ++
 rtl/sum_serie_ctrl_sum1b.sv | 22 ++
 rtl/sum_serie_ctrl.sv | 144 ++++++++++++++
 tb/tb_sum_serie_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sum_serie_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sum_serie_pkg
// Description : Shared types and constants for the bit-serial adder sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sum_serie_pkg;

  localparam int SUM_SERIE_N_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter must index 0..N-1 and never collapse to zero width.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : sum_serie_pkg
`default_nettype wire

// File: rtl/sum_serie_ctrl_sum1b.sv
`default_nettype none
// ============================================================================
// Module      : sum1b
// Description : 1-bit full adder, the single arithmetic cell of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module sum1b (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  logic w_p;

  assign w_p  = a_i ^ b_i;
  assign s_o  = w_p ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & w_p);

endmodule : sum1b
`default_nettype wire

// File: rtl/sum_serie_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sum_serie_ctrl
// Description : Bit-serial N-bit adder, one sum1b step per clock, LSB first,
//               valid/ready on both sides. Option macro: SUM_SERIE_OVF_EN
//               (adds registered signed-overflow output ov_o).
// Revision    : 1.0 - initial release
// ============================================================================
module sum_serie_ctrl
  import sum_serie_pkg::*;
#(
  parameter int N = SUM_SERIE_N_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         ci_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] s_o,
  output logic         co_o
`ifdef SUM_SERIE_OVF_EN
  ,
  output logic         ov_o
`endif
);

  localparam int            CW         = cnt_width(N);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(N - 1);

  state_t        r_state;
  state_t        w_state_nxt;

  logic [N-1:0]  r_a_sr;
  logic [N-1:0]  r_b_sr;
  logic [N-1:0]  r_s_sr;
  logic          r_carry;
  logic [CW-1:0] r_cnt;

  logic [N-1:0]  r_sum;
  logic          r_co;

  logic          w_sum_bit;
  logic          w_co_bit;
  logic          w_accept;
  logic          w_last;
  logic [N-1:0]  w_s_shift;

  sum1b u_sum1b (
    .a_i  (r_a_sr[0]),
    .b_i  (r_b_sr[0]),
    .ci_i (r_carry),
    .s_o  (w_sum_bit),
    .co_o (w_co_bit)
  );

  assign w_accept  = in_valid_i & in_ready_o;
  assign w_last    = (r_state == RUN) && (r_cnt == C_CNT_LAST);
  assign w_s_shift = {w_sum_bit, r_s_sr[N-1:1]};

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)    w_state_nxt = RUN;
      RUN:     if (w_last)      w_state_nxt = DONE;
      DONE:    if (out_ready_i) w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  // in_ready is masked by reset so nothing can be accepted on a reset edge.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (r_state)
      IDLE:    in_ready_o  = ~rst_i;
      RUN:     ;
      DONE:    out_valid_o = 1'b1;
      default: ;
    endcase
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_co    <= 1'b0;
    end else if (w_accept) begin
      r_a_sr  <= a_i;
      r_b_sr  <= b_i;
      r_carry <= ci_i;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a_sr  <= r_a_sr >> 1;
      r_b_sr  <= r_b_sr >> 1;
      r_s_sr  <= w_s_shift;
      r_carry <= w_co_bit;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum <= w_s_shift;
        r_co  <= w_co_bit;
      end
    end
  end

  assign s_o  = r_sum;
  assign co_o = r_co;

`ifdef SUM_SERIE_OVF_EN
  logic r_ov;

  // Before the final step r_carry is the carry into the MSB.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ov <= 1'b0;
    end else if (w_last) begin
      r_ov <= r_carry ^ w_co_bit;
    end
  end

  assign ov_o = r_ov;
`endif

endmodule : sum_serie_ctrl
`default_nettype wire

// File: tb/tb_sum_serie_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_serie_ctrl
// Description : Scoreboard bench for sum_serie_ctrl with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_serie_ctrl;

  localparam int N = 8;

  typedef struct packed {
    logic [7:0] s;
    logic       co;
    logic       ov;
  } exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         ci = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] s;
  logic         co;
  logic         ov;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  exp_t q[$];

  logic pend_rdy = 1'b0;
  logic prev_valid = 1'b0;

  sum_serie_ctrl #(.N(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .ci_i        (ci),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .s_o         (s),
    .co_o        (co)
`ifdef SUM_SERIE_OVF_EN
    ,
    .ov_o        (ov)
`endif
  );

`ifndef SUM_SERIE_OVF_EN
  assign ov = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Caller is in the posedge+1 phase; returns in the same phase after the accept edge.
  task automatic do_op(input logic [7:0] va, input logic [7:0] vb, input logic vci,
                       input bit push, input exp_t e);
    int k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: in_ready stayed %0b, required 1", in_ready);
    end
    in_valid = 1'b1;
    a = va;
    b = vb;
    ci = vci;
    if (push) q.push_back(e);
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
    end
  endtask

  // Monitor: pops the scoreboard at every handoff, also checks latency and ready return.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pend_rdy   <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      if (pend_rdy) chk("in_ready_after_handoff", 32'(in_ready), 32'd1);
      pend_rdy <= 1'b0;
      if (out_valid && !prev_valid) chk("latency", cyc - acc_cyc, N);
      prev_valid <= out_valid;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: s=%0h co=%0b with empty scoreboard", s, co);
        end else begin
          e = q.pop_front();
          chk("sum", 32'(s), 32'(e.s));
          chk("carry_out", 32'(co), 32'(e.co));
`ifdef SUM_SERIE_OVF_EN
          chk("overflow", 32'(ov), 32'(e.ov));
`endif
          pend_rdy <= 1'b1;
        end
      end
    end
  end

  vec_t vecs[7];

  initial begin
    exp_t e;
    vecs[0] = '{a: 8'h5A, b: 8'h33, ci: 1'b0, s: 8'h8D, co: 1'b0, ov: 1'b1};
    vecs[1] = '{a: 8'hFF, b: 8'h01, ci: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, ci: 1'b1, s: 8'hFF, co: 1'b1, ov: 1'b0};
    vecs[3] = '{a: 8'h7F, b: 8'h01, ci: 1'b0, s: 8'h80, co: 1'b0, ov: 1'b1};
    vecs[4] = '{a: 8'h80, b: 8'h80, ci: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b1};
    vecs[5] = '{a: 8'h40, b: 8'h10, ci: 1'b0, s: 8'h50, co: 1'b0, ov: 1'b0};
    vecs[6] = '{a: 8'hAA, b: 8'h55, ci: 1'b1, s: 8'h00, co: 1'b1, ov: 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_ready_during_reset", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_s", 32'(s), 32'd0);
    chk("reset_co", 32'(co), 32'd0);
    chk("reset_ov", 32'(ov), 32'd0);
    @(posedge clk); #1;

    // Directed vectors, consumer always ready
    for (int i = 0; i < 7; i++) begin
      e = '{s: vecs[i].s, co: vecs[i].co, ov: vecs[i].ov};
      do_op(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b1, e);
    end
    drain();

    // Back-pressure: result must hold and a pending operand set must wait
    out_ready = 1'b0;
    do_op(8'h10, 8'h20, 1'b0, 1'b1, '{s: 8'h30, co: 1'b0, ov: 1'b0});
    for (int k = 0; k < 40 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    chk("bp_valid_reached", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      a = 8'h77;
      b = 8'h11;
      @(negedge clk);
      chk("bp_valid_hold", 32'(out_valid), 32'd1);
      chk("bp_s_hold", 32'(s), 32'h30);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    @(posedge clk); #1;

    // Reset in the middle of RUN discards the operation
    do_op(8'h12, 8'h34, 1'b0, 1'b0, '0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrun_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_s", 32'(s), 32'd0);
    chk("midrun_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    do_op(8'h01, 8'h01, 1'b0, 1'b1, '{s: 8'h02, co: 1'b0, ov: 1'b0});
    drain();

    // Operand wiggle after accept has no effect
    do_op(8'h3C, 8'h0F, 1'b1, 1'b1, '{s: 8'h4C, co: 1'b0, ov: 1'b0});
    for (int k = 0; k < N + 2; k++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      ci = 1'($urandom);
      @(posedge clk); #1;
    end
    drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sum_serie_ctrl
`default_nettype wire
